// File: rtl/guess_pkg.sv
// Shared types and constants for the guess entry stage.
package guess_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HAVE_ONES = 2'd1,
    PRESENT   = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/guess_entry_button_debouncer.sv
// One raw button: 2-flop synchronizer, persistence counter, rising-level press pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Count only an unbroken run of samples disagreeing with the accepted level.
      if (sync_p1 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_p1;
          press <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/guess_entry.sv
// Builds a two-digit BCD guess from debounced confirm buttons and offers it
// to the game core over a valid/ready handshake.
module guess_entry
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] input_ones,
  input  logic       confirm1,
  input  logic       confirm2,
  output logic [7:0] guess,
  output logic       guess_valid,
  input  logic       guess_ready,
  output logic       entry_error,
  output logic [1:0] stage
);

  logic       btn1_level, btn1_press;
  logic       btn2_level, btn2_press;
  logic       hit1, hit2;
  logic [3:0] dig_p0, dig_p1;
  logic       digit_ok;

  state_t     state, state_next;
  logic [3:0] ones_q, ones_next;
  logic       err_next;
  logic       load_guess;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn1 (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(confirm1),
    .level  (btn1_level),
    .press  (btn1_press)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn2 (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(confirm2),
    .level  (btn2_level),
    .press  (btn2_press)
  );

  assign hit1     = btn1_press & btn1_level;
  assign hit2     = btn2_press & btn2_level;
  assign digit_ok = is_bcd(dig_p1);
  assign stage    = state;

  // Digit switches: two-flop synchronizer stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_p0 <= 4'd0;
      dig_p1 <= 4'd0;
    end else begin
      dig_p0 <= input_ones;
      dig_p1 <= dig_p0;
    end
  end

  always_comb begin
    state_next = state;
    ones_next  = ones_q;
    err_next   = 1'b0;
    load_guess = 1'b0;
    case (state)
      IDLE: begin
        if (hit1) begin
          if (digit_ok) begin
            ones_next  = dig_p1;
            state_next = HAVE_ONES;
          end else begin
            err_next = 1'b1;
          end
        end
        if (hit2) err_next = 1'b1;
      end
      HAVE_ONES: begin
        if (hit1) begin
          if (digit_ok) ones_next = dig_p1;
          else          err_next  = 1'b1;
        end
        // A tens press coinciding with a ones press loses to the ones press.
        if (hit2) begin
          if (hit1 || !digit_ok) begin
            err_next = 1'b1;
          end else begin
            load_guess = 1'b1;
            state_next = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (hit1 || hit2) err_next = 1'b1;
        if (guess_ready)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM and handshake register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ones_q      <= 4'd0;
      guess       <= 8'h00;
      guess_valid <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      state       <= state_next;
      ones_q      <= ones_next;
      guess_valid <= (state_next == PRESENT);
      entry_error <= err_next;
      if (load_guess) guess <= {dig_p1, ones_q};
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry with a window-based behavioural model.
module tb_guess_entry;

  localparam int DB = 4;
  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] input_ones = 4'd0;
  logic       confirm1 = 1'b0;
  logic       confirm2 = 1'b0;
  logic       guess_ready = 1'b0;
  logic [7:0] guess;
  logic       guess_valid;
  logic       entry_error;
  logic [1:0] stage;

  guess_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .input_ones (input_ones),
    .confirm1   (confirm1),
    .confirm2   (confirm2),
    .guess      (guess),
    .guess_valid(guess_valid),
    .guess_ready(guess_ready),
    .entry_error(entry_error),
    .stage      (stage)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int errcnt = 0;
  int vldcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw sample histories (bit i = sample taken i edges ago).
  logic [DB+1:0] h1, h2;
  logic [3:0]    hd0, hd1, hd2;
  logic          ml1, ml2, mp1, mp2, ok;
  logic [1:0]    mst;
  logic [3:0]    mones;
  logic [7:0]    mguess;
  logic          mvld, merr;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        h1 = '0; h2 = '0; hd0 = 0; hd1 = 0; hd2 = 0;
        ml1 = 0; ml2 = 0; mp1 = 0; mp2 = 0;
        mst = 0; mones = 0; mguess = 0; mvld = 0; merr = 0;
      end else begin
        h1 = {h1[DB:0], confirm1};
        h2 = {h2[DB:0], confirm2};
        hd2 = hd1; hd1 = hd0; hd0 = input_ones;
        ok = (hd2 <= 4'd9);
        merr = 0;
        case (mst)
          2'd0: begin
            if (mp1) begin
              if (ok) begin mones = hd2; mst = 2'd1; end
              else merr = 1;
            end
            if (mp2) merr = 1;
          end
          2'd1: begin
            if (mp1) begin
              if (ok) mones = hd2;
              else merr = 1;
            end
            if (mp2) begin
              if (mp1 || !ok) merr = 1;
              else begin mguess = {hd2, mones}; mst = 2'd2; end
            end
          end
          default: begin
            if (mp1 || mp2) merr = 1;
            if (guess_ready) mst = 2'd0;
          end
        endcase
        mvld = (mst == 2'd2);
        // Level flips once DB consecutive synchronized samples disagree with it.
        mp1 = 0;
        if (h1[DB+1:2] == {DB{~ml1}}) begin ml1 = ~ml1; mp1 = ml1; end
        mp2 = 0;
        if (h2[DB+1:2] == {DB{~ml2}}) begin ml2 = ~ml2; mp2 = ml2; end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("guess", 32'(guess), 32'(mguess));
      check("guess_valid", 32'(guess_valid), 32'(mvld));
      check("entry_error", 32'(entry_error), 32'(merr));
      check("stage", 32'(stage), 32'(mst));
      if (entry_error) errcnt++;
      if (guess_valid) vldcnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int b);
    if (b[0]) confirm1 = 1'b1;
    if (b[1]) confirm2 = 1'b1;
    tick(10);
    confirm1 = 1'b0;
    confirm2 = 1'b0;
    tick(10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  int e0, v0;

  initial begin
    reset = 1'b1;
    tick(3);
    for (int i = 0; i < 20; i++) begin
      confirm1 = i[0];
      confirm2 = ~i[0];
      tick(1);
    end
    confirm1 = 1'b0;
    confirm2 = 1'b0;
    check("rst_stage", 32'(stage), 0);
    check("rst_guess", 32'(guess), 0);
    check("rst_valid", 32'(guess_valid), 0);
    check("rst_error", 32'(entry_error), 0);
    reset = 1'b0;
    tick(10);
    check("post_rst_stage", 32'(stage), 0);
    check("post_rst_valid", 32'(guess_valid), 0);

    // Clean ones press: state changes on the edge after the press pulse.
    input_ones = 7;
    confirm1 = 1'b1;
    tick(6);
    check("lat_before", 32'(stage), 0);
    tick(1);
    check("lat_after", 32'(stage), 1);
    tick(3);
    confirm1 = 1'b0;
    tick(10);
    check("ones_valid_low", 32'(guess_valid), 0);
    push(2);
    check("g77_guess", 32'(guess), 32'h77);
    check("g77_valid", 32'(guess_valid), 1);
    tick(10);
    check("g77_hold", 32'(guess_valid), 1);
    guess_ready = 1'b1;
    tick(1);
    check("g77_xfer_valid", 32'(guess_valid), 0);
    check("g77_xfer_stage", 32'(stage), 0);
    check("g77_keep_guess", 32'(guess), 32'h77);
    guess_ready = 1'b0;

    // Bouncing contact settles into one press.
    do_reset();
    input_ones = 4;
    e0 = errcnt;
    for (int i = 0; i < 20; i++) begin
      confirm1 = ((i % 4) < 2);
      tick(1);
    end
    check("bounce_no_press", 32'(stage), 0);
    confirm1 = 1'b1;
    tick(10);
    check("bounce_stage", 32'(stage), 1);
    check("bounce_no_err", 32'(errcnt - e0), 0);
    confirm1 = 1'b0;
    tick(10);

    // Rejected presses in IDLE.
    do_reset();
    input_ones = 12;
    e0 = errcnt;
    push(1);
    check("bad_digit_err", 32'(errcnt - e0), 1);
    check("bad_digit_stage", 32'(stage), 0);
    e0 = errcnt;
    push(2);
    check("idle_tens_err", 32'(errcnt - e0), 1);
    check("idle_tens_stage", 32'(stage), 0);

    // Overwrite ones, then tens; presses while presenting are rejected.
    input_ones = 3; push(1);
    input_ones = 5; push(1);
    input_ones = 2; push(2);
    check("g25_guess", 32'(guess), 32'h25);
    check("g25_valid", 32'(guess_valid), 1);
    input_ones = 9;
    e0 = errcnt;
    push(1);
    check("present_p1_err", 32'(errcnt - e0), 1);
    check("present_guess", 32'(guess), 32'h25);
    e0 = errcnt;
    push(2);
    check("present_p2_err", 32'(errcnt - e0), 1);
    guess_ready = 1'b1;
    tick(1);
    check("g25_xfer_valid", 32'(guess_valid), 0);
    check("g25_xfer_stage", 32'(stage), 0);
    guess_ready = 1'b0;

    // Simultaneous presses in HAVE_ONES: ones taken, tens rejected.
    input_ones = 6; push(1);
    input_ones = 8;
    e0 = errcnt;
    push(3);
    check("simul_err", 32'(errcnt - e0), 1);
    check("simul_stage", 32'(stage), 1);
    input_ones = 1; push(2);
    check("g18_guess", 32'(guess), 32'h18);
    guess_ready = 1'b1;
    tick(1);
    check("g18_xfer", 32'(guess_valid), 0);

    // Ready held high: valid for exactly one cycle.
    v0 = vldcnt;
    input_ones = 4; push(1);
    input_ones = 0; push(2);
    check("held_ready_vld", 32'(vldcnt - v0), 1);
    check("held_ready_guess", 32'(guess), 32'h04);
    check("held_ready_stage", 32'(stage), 0);
    guess_ready = 1'b0;

    // Asynchronous reset mid-entry.
    input_ones = 1; push(1);
    check("mid_stage", 32'(stage), 1);
    reset = 1'b1;
    #1;
    check("async_stage", 32'(stage), 0);
    check("async_valid", 32'(guess_valid), 0);
    tick(2);
    reset = 1'b0;
    tick(10);
    check("after_async_stage", 32'(stage), 0);
    check("after_async_guess", 32'(guess), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
